// File: rtl/chrono_pkg.sv
// +----------------------------------------------------------------------------+
// | chrono_pkg : shared types, limits and helpers for the chrono_core watch    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package chrono_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_EDIT  = 2'd1,
        MODE_ALARM = 2'd2,
        MODE_TIMER = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        FIELD_HI = 2'd0,
        FIELD_LO = 2'd1,
        FIELD_EN = 2'd2
    } field_e;

    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [6:0] TMIN_MAX = 7'd99;

    function automatic logic [3:0] mode_to_onehot(input mode_e m);
        return 4'b0001 << m;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_CLOCK: return MODE_EDIT;
            MODE_EDIT:  return MODE_ALARM;
            MODE_ALARM: return MODE_TIMER;
            default:    return MODE_CLOCK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_press.sv
// +----------------------------------------------------------------------------+
// | btn_press : hold counter turning a raw button into one registered pulse    |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module btn_press #(
    parameter int PRESS_CYCLES = 15_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int              CNT_W    = $clog2(PRESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PRESS_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // The counter saturates so that only the crossing of CNT_LAST fires.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (!btn_i) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            press_d = (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/chrono_core.sv
// +----------------------------------------------------------------------------+
// | chrono_core : 24 h clock, live edit, alarms and countdown timer for watch  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module chrono_core
    import chrono_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int PRESS_CYCLES = 15_000_000,
    parameter int NUM_ALARMS   = 2,
    parameter int ASEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_mode,
    input  logic                  btn_shift,
    input  logic                  btn_inc,
    input  logic                  btn_start,
    output logic [6:0]            disp_hi,
    output logic [6:0]            disp_lo,
    output logic [3:0]            mode_onehot,
    output logic [1:0]            edit_field,
    output logic [ASEL_W-1:0]     alarm_sel,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic [NUM_ALARMS-1:0] alarm_hit,
    output logic                  timer_running,
    output logic                  timer_done
);

    localparam int               DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam logic [ASEL_W-1:0] SEL_LAST = ASEL_W'(NUM_ALARMS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_w;

    logic [3:0] btn_raw_w, press_w;
    logic       act_mode_w, act_shift_w, act_inc_w, act_start_w, any_press_w;

    mode_e                 mode_q, mode_d;
    field_e                field_q, field_d;
    logic [4:0]            hh_q, hh_d;
    logic [5:0]            mm_q, mm_d, ss_q, ss_d;
    logic [4:0]            al_hh_q [NUM_ALARMS];
    logic [4:0]            al_hh_d [NUM_ALARMS];
    logic [5:0]            al_mm_q [NUM_ALARMS];
    logic [5:0]            al_mm_d [NUM_ALARMS];
    logic [ASEL_W-1:0]     sel_q, sel_d;
    logic [NUM_ALARMS-1:0] aen_q, aen_d, ahit_q, ahit_d;
    logic [6:0]            tmm_q, tmm_d;
    logic [5:0]            tss_q, tss_d;
    logic                  trun_q, trun_d, tdone_q, tdone_d;

    logic [4:0] clk_hh_w;
    logic [5:0] clk_mm_w, clk_ss_w;
    logic       min_roll_w;
    logic [6:0] disp_hi_d, disp_lo_d;

    assign tick_w = (div_q == DIV_LAST);
    assign div_d  = tick_w ? '0 : div_q + DIV_W'(1);

    assign btn_raw_w = {btn_start, btn_inc, btn_shift, btn_mode};

    for (genvar b = 0; b < 4; b++) begin : g_btn
        btn_press #(
            .PRESS_CYCLES (PRESS_CYCLES)
        ) u_btn (
            .clk     (clk),
            .reset   (reset),
            .btn_i   (btn_raw_w[b]),
            .press_o (press_w[b])
        );
    end

    // Only the highest-priority pulse acts: mode > shift > inc > start.
    assign act_mode_w  = press_w[0];
    assign act_shift_w = press_w[1] & ~press_w[0];
    assign act_inc_w   = press_w[2] & ~|press_w[1:0];
    assign act_start_w = press_w[3] & ~|press_w[2:0];
    assign any_press_w = |press_w;

    always_comb begin
        clk_ss_w   = ss_q + 6'd1;
        clk_mm_w   = mm_q;
        clk_hh_w   = hh_q;
        min_roll_w = 1'b0;
        if (ss_q == MIN_MAX) begin
            clk_ss_w   = '0;
            min_roll_w = 1'b1;
            if (mm_q == MIN_MAX) begin
                clk_mm_w = '0;
                clk_hh_w = (hh_q == HOUR_MAX) ? '0 : hh_q + 5'd1;
            end else begin
                clk_mm_w = mm_q + 6'd1;
            end
        end
    end

    always_comb begin
        mode_d  = mode_q;
        field_d = field_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        al_hh_d = al_hh_q;
        al_mm_d = al_mm_q;
        sel_d   = sel_q;
        aen_d   = aen_q;
        ahit_d  = ahit_q;
        tmm_d   = tmm_q;
        tss_d   = tss_q;
        trun_d  = trun_q;
        tdone_d = tdone_q;

        if (any_press_w) begin
            ahit_d  = '0;
            tdone_d = 1'b0;
        end

        // An EDIT inc rewrites the time, so the coincident tick is dropped.
        if (tick_w && !(mode_q == MODE_EDIT && act_inc_w)) begin
            hh_d = clk_hh_w;
            mm_d = clk_mm_w;
            ss_d = clk_ss_w;
            if (min_roll_w) begin
                for (int i = 0; i < NUM_ALARMS; i++) begin
                    if (aen_q[i] && al_hh_q[i] == clk_hh_w && al_mm_q[i] == clk_mm_w) begin
                        ahit_d[i] = 1'b1;
                    end
                end
            end
        end

        if (tick_w && trun_q) begin
            if (tss_q == '0) begin
                tss_d = MIN_MAX;
                tmm_d = tmm_q - 7'd1;
            end else begin
                tss_d = tss_q - 6'd1;
            end
            if (tmm_q == '0 && tss_q == 6'd1) begin
                trun_d  = 1'b0;
                tdone_d = 1'b1;
            end
        end

        if (act_mode_w) begin
            mode_d  = next_mode(mode_q);
            field_d = FIELD_HI;
        end else begin
            case (mode_q)
                MODE_EDIT: begin
                    if (act_shift_w) field_d = (field_q == FIELD_HI) ? FIELD_LO : FIELD_HI;
                    if (act_inc_w) begin
                        if (field_q == FIELD_HI) hh_d = (hh_q == HOUR_MAX) ? '0 : hh_q + 5'd1;
                        else                     mm_d = (mm_q == MIN_MAX) ? '0 : mm_q + 6'd1;
                        ss_d = '0;
                    end
                end
                MODE_ALARM: begin
                    if (act_shift_w) begin
                        case (field_q)
                            FIELD_HI: field_d = FIELD_LO;
                            FIELD_LO: field_d = FIELD_EN;
                            default:  field_d = FIELD_HI;
                        endcase
                    end
                    if (act_inc_w) begin
                        case (field_q)
                            FIELD_HI: al_hh_d[sel_q] = (al_hh_q[sel_q] == HOUR_MAX) ? '0 : al_hh_q[sel_q] + 5'd1;
                            FIELD_LO: al_mm_d[sel_q] = (al_mm_q[sel_q] == MIN_MAX) ? '0 : al_mm_q[sel_q] + 6'd1;
                            default:  aen_d[sel_q]   = ~aen_q[sel_q];
                        endcase
                    end
                    if (act_start_w) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + ASEL_W'(1);
                end
                MODE_TIMER: begin
                    if (trun_q) begin
                        if (act_start_w) trun_d = 1'b0;
                    end else begin
                        if (act_shift_w) field_d = (field_q == FIELD_HI) ? FIELD_LO : FIELD_HI;
                        if (act_inc_w) begin
                            if (field_q == FIELD_HI) tmm_d = (tmm_q == TMIN_MAX) ? '0 : tmm_q + 7'd1;
                            else                     tss_d = (tss_q == MIN_MAX) ? '0 : tss_q + 6'd1;
                        end
                        if (act_start_w && (tmm_q != '0 || tss_q != '0)) trun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            mode_q  <= MODE_CLOCK;
            field_q <= FIELD_HI;
            hh_q    <= '0;
            mm_q    <= '0;
            ss_q    <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_hh_q[i] <= '0;
                al_mm_q[i] <= '0;
            end
            sel_q   <= '0;
            aen_q   <= '0;
            ahit_q  <= '0;
            tmm_q   <= '0;
            tss_q   <= '0;
            trun_q  <= 1'b0;
            tdone_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            mode_q  <= mode_d;
            field_q <= field_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            al_hh_q <= al_hh_d;
            al_mm_q <= al_mm_d;
            sel_q   <= sel_d;
            aen_q   <= aen_d;
            ahit_q  <= ahit_d;
            tmm_q   <= tmm_d;
            tss_q   <= tss_d;
            trun_q  <= trun_d;
            tdone_q <= tdone_d;
        end
    end

    always_comb begin
        disp_hi_d = {2'b00, hh_q};
        disp_lo_d = {1'b0, mm_q};
        case (mode_q)
            MODE_ALARM: begin
                disp_hi_d = {2'b00, al_hh_q[sel_q]};
                disp_lo_d = {1'b0, al_mm_q[sel_q]};
            end
            MODE_TIMER: begin
                disp_hi_d = tmm_q;
                disp_lo_d = {1'b0, tss_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_hi       <= '0;
            disp_lo       <= '0;
            mode_onehot   <= mode_to_onehot(MODE_CLOCK);
            edit_field    <= '0;
            alarm_sel     <= '0;
            alarm_en      <= '0;
            alarm_hit     <= '0;
            timer_running <= 1'b0;
            timer_done    <= 1'b0;
        end else begin
            disp_hi       <= disp_hi_d;
            disp_lo       <= disp_lo_d;
            mode_onehot   <= mode_to_onehot(mode_q);
            edit_field    <= field_q;
            alarm_sel     <= sel_q;
            alarm_en      <= aen_q;
            alarm_hit     <= ahit_q;
            timer_running <= trun_q;
            timer_done    <= tdone_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_chrono_core.sv
// +----------------------------------------------------------------------------+
// | tb_chrono_core : randomized bench against a seconds-based watch model      |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_chrono_core;

    localparam int CLK_HZ = 10;
    localparam int PRESS  = 3;
    localparam int NA     = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      btn = '0;   // bit0 mode, bit1 shift, bit2 inc, bit3 start
    logic [6:0]      disp_hi, disp_lo;
    logic [3:0]      mode_onehot;
    logic [1:0]      edit_field;
    logic [0:0]      alarm_sel;
    logic [NA-1:0]   alarm_en, alarm_hit;
    logic            timer_running, timer_done;

    chrono_core #(
        .CLK_HZ       (CLK_HZ),
        .PRESS_CYCLES (PRESS),
        .NUM_ALARMS   (NA)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_mode      (btn[0]),
        .btn_shift     (btn[1]),
        .btn_inc       (btn[2]),
        .btn_start     (btn[3]),
        .disp_hi       (disp_hi),
        .disp_lo       (disp_lo),
        .mode_onehot   (mode_onehot),
        .edit_field    (edit_field),
        .alarm_sel     (alarm_sel),
        .alarm_en      (alarm_en),
        .alarm_hit     (alarm_hit),
        .timer_running (timer_running),
        .timer_done    (timer_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time of day in seconds, alarms in minute-of-day, timer in seconds.
    int          m_secs, m_tsecs, m_mode, m_field, m_sel, m_ecount;
    int          m_amin [NA];
    logic [NA-1:0] m_aen, m_ahit;
    bit          m_trun, m_tdone, m_valid;
    int          m_run [4];
    logic [3:0]  m_pend;
    int          x_hi, x_lo, x_oh, x_field, x_sel, x_aen, x_ahit, x_trun, x_tdone;

    task automatic model_reset();
        m_secs = 0; m_tsecs = 0; m_mode = 0; m_field = 0; m_sel = 0; m_ecount = 0;
        for (int i = 0; i < NA; i++) m_amin[i] = 0;
        m_aen = '0; m_ahit = '0; m_trun = 0; m_tdone = 0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_pend = '0;
    endtask

    task automatic model_snapshot();
        case (m_mode)
            2: begin x_hi = m_amin[m_sel] / 60; x_lo = m_amin[m_sel] % 60; end
            3: begin x_hi = m_tsecs / 60;       x_lo = m_tsecs % 60;       end
            default: begin x_hi = m_secs / 3600; x_lo = (m_secs / 60) % 60; end
        endcase
        x_oh = 1 << m_mode; x_field = m_field; x_sel = m_sel;
        x_aen = m_aen; x_ahit = m_ahit; x_trun = m_trun; x_tdone = m_tdone;
    endtask

    task automatic model_apply(input logic [3:0] p, input bit tick);
        int act, h, m, s;
        bit run_old;
        act = -1;
        for (int b = 3; b >= 0; b--) if (p[b]) act = b;
        run_old = m_trun;
        if (act >= 0) begin m_ahit = '0; m_tdone = 0; end
        if (tick && !(m_mode == 1 && act == 2)) begin
            m_secs = (m_secs + 1) % 86400;
            if (m_secs % 60 == 0)
                for (int i = 0; i < NA; i++)
                    if (m_aen[i] && m_amin[i] == m_secs / 60) m_ahit[i] = 1'b1;
        end
        if (tick && run_old) begin
            m_tsecs--;
            if (m_tsecs == 0) begin m_trun = 0; m_tdone = 1; end
        end
        if (act == 0) begin
            m_mode = (m_mode + 1) % 4; m_field = 0;
        end else if (act > 0) begin
            case (m_mode)
                1: begin
                    if (act == 1) m_field ^= 1;
                    if (act == 2) begin
                        h = m_secs / 3600; m = (m_secs / 60) % 60;
                        if (m_field == 0) h = (h + 1) % 24; else m = (m + 1) % 60;
                        m_secs = h * 3600 + m * 60;
                    end
                end
                2: begin
                    h = m_amin[m_sel] / 60; m = m_amin[m_sel] % 60;
                    if (act == 1) m_field = (m_field + 1) % 3;
                    if (act == 2) begin
                        if (m_field == 0)      h = (h + 1) % 24;
                        else if (m_field == 1) m = (m + 1) % 60;
                        else                   m_aen[m_sel] = ~m_aen[m_sel];
                        m_amin[m_sel] = h * 60 + m;
                    end
                    if (act == 3) m_sel = (m_sel + 1) % NA;
                end
                3: begin
                    if (run_old) begin
                        if (act == 3) m_trun = 0;
                    end else begin
                        m = m_tsecs / 60; s = m_tsecs % 60;
                        if (act == 1) m_field ^= 1;
                        if (act == 2) begin
                            if (m_field == 0) m = (m + 1) % 100; else s = (s + 1) % 60;
                            m_tsecs = m * 60 + s;
                        end
                        if (act == 3 && m_tsecs != 0) m_trun = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Outputs are registered, so the value expected after an edge is the state before it.
    always @(posedge clk) begin
        if (reset) begin
            model_reset();
            model_snapshot();
            m_valid = 1;
        end else begin
            model_snapshot();
            m_ecount++;
            model_apply(m_pend, (m_ecount % CLK_HZ) == 0);
            for (int b = 0; b < 4; b++) begin
                m_run[b] = btn[b] ? m_run[b] + 1 : 0;
                m_pend[b] = (m_run[b] == PRESS);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("disp_hi", disp_hi, x_hi);
            check("disp_lo", disp_lo, x_lo);
            check("mode_onehot", mode_onehot, x_oh);
            check("edit_field", edit_field, x_field);
            check("alarm_sel", alarm_sel, x_sel);
            check("alarm_en", alarm_en, x_aen);
            check("alarm_hit", alarm_hit, x_ahit);
            check("timer_running", timer_running, x_trun);
            check("timer_done", timer_done, x_tdone);
        end
    end

    task automatic hold(input logic [3:0] mask, input int n, input int idle);
        btn = mask;
        repeat (n) @(negedge clk);
        btn = '0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic press(input int b);
        logic [3:0] mk;
        mk = '0;
        mk[b] = 1'b1;
        hold(mk, PRESS + $urandom_range(0, 3), 2);
    endtask

    task automatic goto_mode(input int t);
        for (int k = 0; k < 4 && m_mode != t; k++) press(0);
    endtask

    initial begin
        int cyc;
        bit tmo;
        logic [3:0] mk;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_mode", mode_onehot, 4'b0001);

        // Short hold, exact hold, long hold
        hold(4'b0001, PRESS - 1, 3);
        check("short_hold", mode_onehot, 4'b0001);
        hold(4'b0001, PRESS, 2);
        check("exact_hold", mode_onehot, 4'b0010);
        hold(4'b0001, 20, 2);
        check("long_hold", mode_onehot, 4'b0100);

        // Clock to 23:59:58 via EDIT, then roll over midnight
        goto_mode(1);
        for (int k = 0; k < 30 && m_secs / 3600 != 23; k++) press(2);
        press(1);
        for (int k = 0; k < 70 && (m_secs / 60) % 60 != 59; k++) press(2);
        cyc = 0;
        while (m_secs != 86398 && cyc < 1000) begin @(negedge clk); cyc++; end
        tmo = (cyc >= 1000);
        check("wait_235958", tmo, 0);
        cyc = 0;
        while (m_secs != 0 && cyc < 100) begin @(negedge clk); cyc++; end
        tmo = (cyc >= 100);
        check("wait_midnight", tmo, 0);
        @(negedge clk);
        check("midnight_hh", disp_hi, 0);
        check("midnight_mm", disp_lo, 0);
        press(1);
        for (int k = 0; k < 30 && m_secs / 3600 != 23; k++) press(2);
        press(2);
        check("edit_hour_wrap", disp_hi, 0);

        // Alarm 0 at 00:02 disabled, alarm 1 at 00:02 enabled
        goto_mode(2);
        for (int a = 0; a < NA; a++) begin
            for (int k = 0; k < 4 && m_sel != a; k++) press(3);
            for (int k = 0; k < 4 && m_field != 0; k++) press(1);
            for (int k = 0; k < 30 && m_amin[a] / 60 != 0; k++) press(2);
            press(1);
            for (int k = 0; k < 70 && m_amin[a] % 60 != 2; k++) press(2);
            press(1);
            if (a == 1 && !m_aen[1]) press(2);
            press(1);
        end
        goto_mode(1);
        for (int k = 0; k < 30 && m_secs / 3600 != 0; k++) press(2);
        press(1);
        press(2);
        for (int k = 0; k < 70 && (m_secs / 60) % 60 != 1; k++) press(2);
        cyc = 0;
        while (m_secs != 120 && cyc < 1000) begin @(negedge clk); cyc++; end
        tmo = (cyc >= 1000);
        check("wait_alarm", tmo, 0);
        @(negedge clk);
        check("alarm_hit_set", alarm_hit, 2'b10);
        press(1);
        check("alarm_hit_clear", alarm_hit, 2'b00);

        // Timer 01:00 countdown to expiry
        goto_mode(3);
        for (int k = 0; k < 110 && m_tsecs / 60 != 1; k++) press(2);
        press(1);
        for (int k = 0; k < 70 && m_tsecs % 60 != 0; k++) press(2);
        press(3);
        check("timer_started", timer_running, 1);
        cyc = 0;
        while (m_trun && cyc < 800) begin @(negedge clk); cyc++; end
        tmo = (cyc >= 800);
        check("wait_timer", tmo, 0);
        @(negedge clk);
        check("timer_done_set", timer_done, 1);
        check("timer_stopped", timer_running, 0);
        check("timer_zero_mm", disp_hi, 0);
        check("timer_zero_ss", disp_lo, 0);
        press(3);
        check("start_at_zero", timer_running, 0);

        // Countdown keeps running in other modes; mode+inc together
        press(1);
        repeat ($urandom_range(1, 3)) press(2);
        press(3);
        press(0);
        press(0);
        repeat (50) @(negedge clk);
        hold(4'b0101, PRESS, 2);
        check("mode_wins", mode_onehot, 4'b0100);

        // Reset mid-hold and mid-countdown
        btn = 4'b0100;
        repeat (2) @(negedge clk);
        btn = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("post_reset_run", timer_running, 0);
        check("post_reset_mode", mode_onehot, 4'b0001);

        // Randomized button traffic
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) mk = 4'($urandom_range(1, 15));
            else begin mk = '0; mk[$urandom_range(0, 3)] = 1'b1; end
            hold(mk, $urandom_range(1, 6), $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(5, 30)) @(negedge clk);
            if ($urandom_range(0, 79) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b0;
            end
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
